// File: rtl/vrf_perf_window_sampler_if.sv
// Record channel of the VRF perf window sampler: one closed-window record per valid/ready beat.
// The master holds every field stable while rec_vld is high and rec_rdy is low.
interface vrf_perf_window_sampler_if #(
    parameter int unsigned CntW    = 32,
    parameter int unsigned WindowW = 16,
    parameter int unsigned PeakW   = 3
);
    logic               rec_vld;
    logic               rec_rdy;
    logic [CntW-1:0]    rec_req;
    logic [CntW-1:0]    rec_conflict;
    logic [CntW-1:0]    rec_hp_block_lp;
    logic [WindowW-1:0] rec_cycles;
    logic [PeakW-1:0]   rec_peak_bank;
    logic               rec_partial;
    logic [15:0]        rec_window_id;

    modport master (
        output rec_vld, rec_req, rec_conflict, rec_hp_block_lp, rec_cycles,
               rec_peak_bank, rec_partial, rec_window_id,
        input  rec_rdy
    );

    modport slave (
        input  rec_vld, rec_req, rec_conflict, rec_hp_block_lp, rec_cycles,
               rec_peak_bank, rec_partial, rec_window_id,
        output rec_rdy
    );
endinterface

// File: rtl/vrf_perf_window_sampler.sv
// Windowed accumulator of VRF arbitration counters; per-bank peak tracking under VRF_PERF_SAMPLER_PEAK_EN.
// Latency: a window closing at edge N is visible on the record channel in cycle N+1 (fall-through FIFO).
// Backpressure: records queue in a FifoDepth FIFO; a push into a full FIFO without a same-cycle pop is dropped and counted.

module vrf_perf_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q, rd_ptr_q;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop_dat_o = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wr_ptr_q[PtrW-1:0]] <= push_dat_i;
    end
endmodule

module vrf_perf_window_sampler #(
    parameter int unsigned NrBanks   = 8,
    parameter int unsigned WindowW   = 16,
    parameter int unsigned CntW      = 32,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [WindowW-1:0]  window_len_i,
    input  logic [7:0]          req_count_i,
    input  logic [7:0]          conflict_count_i,
    input  logic [7:0]          hp_block_lp_i,
    input  logic [NrBanks-1:0]  bank_conflict_i,
    vrf_perf_window_sampler_if.master rec,
    output logic [15:0]         dropped_o,
    output logic                busy_o
);
    localparam int unsigned PeakW = $clog2(NrBanks);

    typedef enum logic [1:0] {Idle, Run, Flush} state_e;

    typedef struct packed {
        logic [CntW-1:0]    req;
        logic [CntW-1:0]    conflict;
        logic [CntW-1:0]    hp_block_lp;
        logic [WindowW-1:0] cycles;
        logic [PeakW-1:0]   peak_bank;
        logic               partial;
        logic [15:0]        window_id;
    } rec_t;

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a, input logic [7:0] b);
        logic [CntW:0] s;
        s = {1'b0, a} + (CntW+1)'(b);
        return s[CntW] ? '1 : s[CntW-1:0];
    endfunction

    state_e             state_q, state_d;
    logic [WindowW-1:0] len_q, len_d, cyc_q, cyc_d;
    logic [CntW-1:0]    acc_req_q, acc_conf_q, acc_hp_q;
    logic [CntW-1:0]    req_sum, conf_sum, hp_sum;
    logic [15:0]        win_id_q, win_id_d, dropped_q, dropped_d;
    logic               acc_clr, acc_en, rec_push;
    rec_t               rec_d, head;
    logic [PeakW-1:0]   peak_bank;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop, pop;

    assign req_sum  = sat_add(acc_req_q,  req_count_i);
    assign conf_sum = sat_add(acc_conf_q, conflict_count_i);
    assign hp_sum   = sat_add(acc_hp_q,   hp_block_lp_i);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cyc_d    = cyc_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        rec_push = 1'b0;
        rec_d    = '0;
        unique case (state_q)
            Idle: begin
                if (enable_i) begin
                    state_d = Run;
                    len_d   = (window_len_i == '0) ? WindowW'(1) : window_len_i;
                    cyc_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            Run: begin
                if (!enable_i) begin
                    state_d = Flush;
                end else if (cyc_q == len_q - WindowW'(1)) begin
                    // Closing cycle: its own inputs belong to the record, next window starts clean.
                    rec_push          = 1'b1;
                    rec_d.req         = req_sum;
                    rec_d.conflict    = conf_sum;
                    rec_d.hp_block_lp = hp_sum;
                    rec_d.cycles      = len_q;
                    rec_d.peak_bank   = peak_bank;
                    rec_d.window_id   = win_id_q;
                    acc_clr           = 1'b1;
                    cyc_d             = '0;
                end else begin
                    acc_en = 1'b1;
                    cyc_d  = cyc_q + WindowW'(1);
                end
            end
            Flush: begin
                state_d = Idle;
                if (cyc_q != '0) begin
                    rec_push          = 1'b1;
                    rec_d.req         = acc_req_q;
                    rec_d.conflict    = acc_conf_q;
                    rec_d.hp_block_lp = acc_hp_q;
                    rec_d.cycles      = cyc_q;
                    rec_d.peak_bank   = peak_bank;
                    rec_d.partial     = 1'b1;
                    rec_d.window_id   = win_id_q;
                end
            end
            default: state_d = Idle;
        endcase
        if (clear_i) begin
            state_d  = Idle;
            cyc_d    = '0;
            acc_clr  = 1'b1;
            acc_en   = 1'b0;
            rec_push = 1'b0;
        end
    end

    assign pop       = rec.rec_vld && rec.rec_rdy;
    assign fifo_pop  = pop && !clear_i;
    assign fifo_push = rec_push && (!fifo_full || pop);
    assign win_id_d  = clear_i ? '0 : (rec_push ? win_id_q + 16'd1 : win_id_q);
    assign dropped_d = clear_i ? '0 :
                       (rec_push && fifo_full && !pop && dropped_q != '1) ? dropped_q + 16'd1 : dropped_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            len_q      <= '0;
            cyc_q      <= '0;
            acc_req_q  <= '0;
            acc_conf_q <= '0;
            acc_hp_q   <= '0;
            win_id_q   <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cyc_q      <= cyc_d;
            acc_req_q  <= acc_clr ? '0 : (acc_en ? req_sum  : acc_req_q);
            acc_conf_q <= acc_clr ? '0 : (acc_en ? conf_sum : acc_conf_q);
            acc_hp_q   <= acc_clr ? '0 : (acc_en ? hp_sum   : acc_hp_q);
            win_id_q   <= win_id_d;
            dropped_q  <= dropped_d;
        end
    end

`ifdef VRF_PERF_SAMPLER_PEAK_EN
    logic [WindowW-1:0] bank_cnt_q [NrBanks];
    logic [WindowW-1:0] bank_inc   [NrBanks];

    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            bank_inc[b] = (bank_conflict_i[b] && bank_cnt_q[b] != '1) ?
                          bank_cnt_q[b] + WindowW'(1) : bank_cnt_q[b];
        end
    end

    // In RUN the closing cycle's flags count; in FLUSH the inputs are ignored.
    always_comb begin
        logic [WindowW-1:0] best, cand;
        peak_bank = '0;
        best      = (state_q == Run) ? bank_inc[0] : bank_cnt_q[0];
        cand      = '0;
        for (int b = 1; b < NrBanks; b++) begin
            cand = (state_q == Run) ? bank_inc[b] : bank_cnt_q[b];
            if (cand > best) begin
                best      = cand;
                peak_bank = PeakW'(b);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NrBanks; b++) bank_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < NrBanks; b++) begin
                bank_cnt_q[b] <= acc_clr ? '0 : (acc_en ? bank_inc[b] : bank_cnt_q[b]);
            end
        end
    end
`else
    logic unused_bank_conflict;
    assign unused_bank_conflict = ^bank_conflict_i;
    assign peak_bank            = '0;
`endif

    logic [$bits(rec_t)-1:0] fifo_dat;

    vrf_perf_fifo #(
        .Width ($bits(rec_t)),
        .Depth (FifoDepth)
    ) u_rec_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clear_i),
        .push_i     (fifo_push),
        .push_dat_i (rec_d),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Fields read as zero while the FIFO is empty so idle/reset outputs are clean.
    assign head                = fifo_empty ? '0 : rec_t'(fifo_dat);
    assign rec.rec_vld         = !fifo_empty;
    assign rec.rec_req         = head.req;
    assign rec.rec_conflict    = head.conflict;
    assign rec.rec_hp_block_lp = head.hp_block_lp;
    assign rec.rec_cycles      = head.cycles;
    assign rec.rec_peak_bank   = head.peak_bank;
    assign rec.rec_partial     = head.partial;
    assign rec.rec_window_id   = head.window_id;
    assign dropped_o           = dropped_q;
    assign busy_o              = (state_q != Idle);
endmodule

// File: tb/tb_vrf_perf_window_sampler.sv
// Randomized and directed bench for vrf_perf_window_sampler against a queue-based window model.
module tb_vrf_perf_window_sampler;
    localparam int NB = 8;
    localparam longint unsigned CMAX = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 0, en = 0;
    logic [15:0] wlen = 0;
    logic [7:0]  req = 0, conf = 0, hp = 0, bank = 0;
    logic [15:0] dropped;
    logic        busy;

    logic        s_clr = 0, s_en = 0;
    logic [15:0] s_len = 0;
    logic [7:0]  s_req = 0, s_zero = 0, s_bank = 0;
    logic [15:0] s_dropped;
    logic        s_busy;

    vrf_perf_window_sampler_if #(.CntW(32), .WindowW(16), .PeakW(3)) rif ();
    vrf_perf_window_sampler_if #(.CntW(8),  .WindowW(16), .PeakW(3)) sif ();

    vrf_perf_window_sampler #(.NrBanks(NB), .WindowW(16), .CntW(32), .FifoDepth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en), .window_len_i(wlen),
        .req_count_i(req), .conflict_count_i(conf), .hp_block_lp_i(hp), .bank_conflict_i(bank),
        .rec(rif), .dropped_o(dropped), .busy_o(busy)
    );

    vrf_perf_window_sampler #(.NrBanks(NB), .WindowW(16), .CntW(8), .FifoDepth(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(s_clr), .enable_i(s_en), .window_len_i(s_len),
        .req_count_i(s_req), .conflict_count_i(s_zero), .hp_block_lp_i(s_zero), .bank_conflict_i(s_bank),
        .rec(sif), .dropped_o(s_dropped), .busy_o(s_busy)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    endtask

    // Model: a window is the list of accepted samples; a record is computed from that list.
    typedef struct { int unsigned req, conf, hp; logic [7:0] bank; } smp_t;
    typedef struct { longint unsigned req, conf, hp; int unsigned cycles, peak, partial, id; } mrec_t;

    smp_t        smp_q[$];
    mrec_t       exp_q[$];
    int          m_state = 0;   // 0 idle, 1 run, 2 flush
    int unsigned m_len = 1, m_id = 0, m_drop = 0;

    function automatic mrec_t make_rec(input bit part);
        mrec_t r;
        int unsigned cnt[NB];
        r.req = 0; r.conf = 0; r.hp = 0;
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        foreach (smp_q[i]) begin
            r.req  += smp_q[i].req;
            r.conf += smp_q[i].conf;
            r.hp   += smp_q[i].hp;
            for (int b = 0; b < NB; b++) cnt[b] += smp_q[i].bank[b];
        end
        if (r.req  > CMAX) r.req  = CMAX;
        if (r.conf > CMAX) r.conf = CMAX;
        if (r.hp   > CMAX) r.hp   = CMAX;
        r.cycles = smp_q.size();
        r.peak = 0;
`ifdef VRF_PERF_SAMPLER_PEAK_EN
        for (int b = 1; b < NB; b++) if (cnt[b] > cnt[r.peak]) r.peak = b;
`endif
        r.partial = part;
        r.id = m_id;
        return r;
    endfunction

    task automatic model_step();
        bit pop, has;
        mrec_t r;
        smp_t s;
        if (clr) begin
            exp_q.delete(); smp_q.delete();
            m_id = 0; m_drop = 0; m_state = 0;
            return;
        end
        pop = (exp_q.size() > 0) && rif.rec_rdy;
        has = 0;
        case (m_state)
            0: if (en) begin
                m_len = (wlen == 0) ? 1 : wlen;
                smp_q.delete();
                m_state = 1;
            end
            1: if (!en) m_state = 2;
            else begin
                s.req = req; s.conf = conf; s.hp = hp; s.bank = bank;
                smp_q.push_back(s);
                if (smp_q.size() == m_len) begin
                    r = make_rec(0); has = 1; smp_q.delete();
                end
            end
            default: begin
                if (smp_q.size() > 0) begin r = make_rec(1); has = 1; end
                smp_q.delete();
                m_state = 0;
            end
        endcase
        if (pop) void'(exp_q.pop_front());
        if (has) begin
            if (exp_q.size() < 4) exp_q.push_back(r);
            else if (m_drop < 65535) m_drop++;
            m_id = (m_id + 1) % 65536;
        end
    endtask

    task automatic compare(input string ph);
        check_eq({ph, ".busy"}, busy, (m_state != 0));
        check_eq({ph, ".dropped"}, dropped, m_drop);
        check_eq({ph, ".valid"}, rif.rec_vld, (exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check_eq({ph, ".req"},     rif.rec_req,         exp_q[0].req);
            check_eq({ph, ".conf"},    rif.rec_conflict,    exp_q[0].conf);
            check_eq({ph, ".hp"},      rif.rec_hp_block_lp, exp_q[0].hp);
            check_eq({ph, ".cycles"},  rif.rec_cycles,      exp_q[0].cycles);
            check_eq({ph, ".peak"},    rif.rec_peak_bank,   exp_q[0].peak);
            check_eq({ph, ".partial"}, rif.rec_partial,     exp_q[0].partial);
            check_eq({ph, ".id"},      rif.rec_window_id,   exp_q[0].id);
        end
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_step();
        #1;
        compare(ph);
    endtask

    task automatic do_clear();
        clr = 1; step("clr"); clr = 0;
    endtask

    task automatic check_all_zero(input string ph);
        check_eq({ph, ".valid"},   rif.rec_vld, 0);
        check_eq({ph, ".req"},     rif.rec_req, 0);
        check_eq({ph, ".conf"},    rif.rec_conflict, 0);
        check_eq({ph, ".hp"},      rif.rec_hp_block_lp, 0);
        check_eq({ph, ".cycles"},  rif.rec_cycles, 0);
        check_eq({ph, ".peak"},    rif.rec_peak_bank, 0);
        check_eq({ph, ".partial"}, rif.rec_partial, 0);
        check_eq({ph, ".id"},      rif.rec_window_id, 0);
        check_eq({ph, ".dropped"}, dropped, 0);
        check_eq({ph, ".busy"},    busy, 0);
    endtask

    initial begin
        bit seen;
        rif.rec_rdy = 1;
        sif.rec_rdy = 1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1;
        repeat (2) step("idle");

        // Basic window
        en = 1; wlen = 4; req = 3; conf = 1; hp = 0;
        do_clear();
        repeat (5) step("basic");
        check_eq("basic.first_req", rif.rec_req, 12);
        check_eq("basic.first_cycles", rif.rec_cycles, 4);
        repeat (12) step("basic");

        // Partial flush
        wlen = 10; req = 2; conf = 0;
        en = 0; step("pre_partial");
        step("pre_partial");
        do_clear();
        en = 1;
        repeat (7) step("partial");
        en = 0;
        step("partial");
        check_eq("partial.busy_flush", busy, 1);
        step("partial");
        check_eq("partial.busy_low", busy, 0);
        check_eq("partial.req", rif.rec_req, 12);
        check_eq("partial.cycles", rif.rec_cycles, 6);
        check_eq("partial.flag", rif.rec_partial, 1);

        // Overflow with len=1
        rif.rec_rdy = 0; req = 1;
        do_clear();
        en = 1; wlen = 1;
        repeat (11) step("ovf");
        check_eq("ovf.dropped", dropped, 6);
        rif.rec_rdy = 1;
        repeat (8) step("ovf_drain");

        // Peak bank tie
        en = 0; step("pre_peak"); step("pre_peak");
        do_clear();
        en = 1; wlen = 8; req = 0; conf = 0;
        step("peak");
        for (int c = 0; c < 8; c++) begin
            bank = (c < 3) ? 8'h20 : ((c < 6) ? 8'h04 : 8'h00);
            step("peak");
        end
        bank = 0;
`ifdef VRF_PERF_SAMPLER_PEAK_EN
        check_eq("peak.bank", rif.rec_peak_bank, 2);
`else
        check_eq("peak.bank", rif.rec_peak_bank, 0);
`endif
        check_eq("peak.valid", rif.rec_vld, 1);

        // Clear mid-window with two records queued
        en = 0; step("pre_clr"); step("pre_clr");
        do_clear();
        rif.rec_rdy = 0; en = 1; wlen = 2; req = 5;
        repeat (6) step("clrq");
        check_eq("clrq.queued_valid", rif.rec_vld, 1);
        clr = 1; step("clrq_clr"); clr = 0;
        check_eq("clrq.valid", rif.rec_vld, 0);
        check_eq("clrq.dropped", dropped, 0);
        check_eq("clrq.busy", busy, 0);
        en = 0; rif.rec_rdy = 1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            clr  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            wlen = 16'($urandom_range(0, 6));
            req  = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            conf = 8'($urandom);
            hp   = 8'($urandom);
            bank = 8'($urandom);
            rif.rec_rdy = (i % 300 < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step("rnd");
        end
        clr = 0;

        // Asynchronous reset mid-window
        do_clear();
        en = 1; wlen = 5; rif.rec_rdy = 0; req = 7;
        repeat (8) step("arst");
        #2 rst_n = 0;
        #1;
        check_all_zero("arst");
        exp_q.delete(); smp_q.delete();
        m_state = 0; m_id = 0; m_drop = 0;
        en = 0; rif.rec_rdy = 1;
        @(posedge clk); #2 rst_n = 1;
        repeat (3) step("post_arst");

        // Saturation on the 8-bit instance
        s_en = 1; s_len = 200; s_req = 8'hFF;
        seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge clk); #1;
            if (sif.rec_vld) seen = 1;
        end
        check_eq("sat.record_seen", seen, 1);
        check_eq("sat.req", sif.rec_req, 8'hFF);
        check_eq("sat.cycles", sif.rec_cycles, 200);
        check_eq("sat.partial", sif.rec_partial, 0);
        check_eq("sat.busy", s_busy, 1);
        check_eq("sat.dropped", s_dropped, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vrf_perf_window_sampler.md
# vrf_perf_window_sampler

Windowed sampler for the VRF bank-arbitration performance counters. It takes the per-cycle request, conflict and HP-blocks-LP increments produced by the VRF performance monitor and accumulates them over a programmable window of cycles. At each window boundary it emits one record into a small FIFO, drained by the testbench or a trace writer over a valid/ready interface. It sits directly downstream of the monitor's combinational increment logic, in the lane-level simulation harness.

## Interface
Parameters:
- NrBanks, 8, number of VRF banks; width of `bank_conflict_i`.
- WindowW, 16, width of the window-length and cycle counters.
- CntW, 32, width of the record accumulators.
- FifoDepth, 4, number of record FIFO entries; must be a power of two and ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear; highest priority.
- enable_i  in  1  sampling enable.
- window_len_i  in  WindowW  window length in cycles; sampled on IDLE→RUN.
- req_count_i  in  8  bank requests this cycle (all banks).
- conflict_count_i  in  8  conflicts this cycle (sum of excess requests over banks).
- hp_block_lp_i  in  8  banks where HP and LP requests collide this cycle.
- bank_conflict_i  in  NrBanks  per-bank conflict flag this cycle.
- rec_valid_o  out  1  head record valid.
- rec_ready_i  in  1  consumer accepts head record.
- rec_req_o  out  CntW  accumulated requests in the window.
- rec_conflict_o  out  CntW  accumulated conflicts in the window.
- rec_hp_block_lp_o  out  CntW  accumulated HP-blocks-LP events in the window.
- rec_cycles_o  out  WindowW  cycles covered by the record.
- rec_peak_bank_o  out  $clog2(NrBanks)  bank with the most conflict cycles in the window.
- rec_partial_o  out  1  record closed early by enable_i deassertion.
- rec_window_id_o  out  16  window sequence number (wraps).
- dropped_o  out  16  records lost because the FIFO was full; saturating.
- busy_o  out  1  high in RUN or FLUSH.

## Operation
- The FSM has three states: IDLE, RUN and FLUSH.
- IDLE→RUN when enable_i=1.
  - Latch `len = max(window_len_i, 1)`.
  - Zero the accumulators and the cycle counter.
  - Inputs in the entry cycle are not accumulated.
- RUN behaviour:
  - Each cycle, add the inputs to the accumulators and increment cyc.
  - Per-bank conflict-cycle counters (WindowW bits, saturating) increment when `bank_conflict_i[b]` is high.
- Window close: occurs in the RUN cycle where `cyc == len-1`.
  - The record includes that cycle's inputs and has `rec_cycles_o = len`, partial=0.
  - Push the record into the FIFO, increment window_id, zero the accumulators.
  - Stay in RUN, so the next window starts with no gap.
- RUN with enable_i=0 → FLUSH.
  - Inputs in this cycle are ignored.
- FLUSH:
  - If cyc>0, push a partial record (partial=1, `rec_cycles_o = cyc`) and increment window_id.
  - Go to IDLE.
  - FLUSH always lasts exactly 1 cycle.
- Accumulator arithmetic: inputs are zero-extended to CntW; the sum saturates at all-ones.
- Peak bank: argmax of the per-bank counters; ties resolve to the lowest index; all-zero gives 0.
- FIFO full:
  - A push is accepted if a pop occurs in the same cycle.
  - Otherwise the record is dropped, dropped_o increments (saturating at 0xFFFF), and window_id still increments.
- clear_i: flushes the FIFO and zeroes the accumulators, window_id and dropped_o; the FSM goes to IDLE. It overrides any push or pop in the same cycle.

## Timing
- Reset values: FSM=IDLE; all outputs 0; FIFO empty.
- Record latency: a window closing at edge N gives rec_valid_o=1 after edge N (visible in cycle N+1); the FIFO is first-word fall-through.
- Handshake: a pop occurs when rec_valid_o && rec_ready_i at the edge. While rec_valid_o=1 and not popped, the record fields are stable.
- len=1: one record every cycle; the FIFO fills if rec_ready_i=0.
- Counter width: cyc is WindowW bits and never exceeds len-1; window_id wraps 0xFFFF→0.
- Asynchronous reset mid-window: in-flight data is discarded, with no partial record.

## Configuration
- `VRF_PERF_SAMPLER_PEAK_EN` defined: the per-bank conflict-cycle counters and argmax are compiled in.
- Not defined:
  - The counters are removed.
  - rec_peak_bank_o is tied to 0.
  - bank_conflict_i is ignored.
  - All other behaviour is identical.

## Test plan
- Basic window: window_len=4, inputs req=3, conflict=1, hp_block_lp=0 every cycle, rec_ready=1.
  - Expect records req=12, conflict=4, cycles=4, partial=0.
  - Window ids 0,1,2… arrive every 4 cycles.
- Partial flush: window_len=10, 6 RUN cycles with req=2, then enable=0.
  - Expect one record req=12, cycles=6, partial=1; busy_o falls 2 cycles after enable drops.
- Overflow: window_len=1, rec_ready=0 for 10 cycles.
  - The FIFO holds 4 records and dropped_o=6.
  - The next record's window_id=10.
- Peak bank (macro on): bank 5 flagged on 3 cycles, bank 2 on 3 cycles, window_len=8.
  - Expect rec_peak_bank_o=2 (tie → lowest index).
  - With the macro off, rec_peak_bank_o=0.
- Clear and reset: clear_i mid-window with 2 records queued.
  - rec_valid_o=0 next cycle, dropped_o=0, FSM in IDLE.
  - Then assert rst_ni low mid-window: all outputs return to 0 immediately.
- Saturation: CntW=8, window_len=200, req=255 every cycle.
  - Expect rec_req_o=255.
